// File: rtl/sr_latch_pkg.sv
// Shared types and next-state rule for the clocked set/reset storage bank.
package sr_latch_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'd0,
        MODE_SET_DOM = 2'd1,
        MODE_RST_DOM = 2'd2,
        MODE_TOGGLE  = 2'd3
    } mode_e;

    // Next stored value of one cell; the S=R=1 case is resolved by mode instead of going X.
    function automatic logic sr_next(input logic q, input logic s, input logic r, input mode_e mode);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00: nxt = q;
            2'b01: nxt = 1'b0;
            2'b10: nxt = 1'b1;
            2'b11: begin
                case (mode)
                    MODE_HOLD:    nxt = q;
                    MODE_SET_DOM: nxt = 1'b1;
                    MODE_RST_DOM: nxt = 1'b0;
                    MODE_TOGGLE:  nxt = ~q;
                    default:      nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One channel of the bank: the stored bit plus its sticky conflict flag.
module sr_cell
    import sr_latch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  s,
    input  logic  r,
    input  mode_e mode,
    input  logic  clr_conf,
    input  logic  rst_val,
    output logic  q,
    output logic  q_next,
    output logic  conf_flag
);

    logic conflict;

    assign conflict = en & s & r;
    assign q_next   = en ? sr_next(q, s, r, mode) : q;

    // A clear in the same cycle as a conflict still leaves this cycle's conflict recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= rst_val;
            conf_flag <= 1'b0;
        end else begin
            q <= q_next;
            if (clr_conf)
                conf_flag <= conflict;
            else if (conflict)
                conf_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of CH clocked set/reset cells with selectable conflict policy, sticky conflict
// flags, a saturating conflict-cycle counter and a registered change pulse.
module sr_latch_bank
    import sr_latch_pkg::*;
#(
    parameter int             CH      = 8,
    parameter int             CNT_W   = 8,
    parameter logic [CH-1:0]  RST_VAL = {CH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CH-1:0]    s,
    input  logic [CH-1:0]    r,
    input  logic [1:0]       mode,
    input  logic             clr_conf,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    qn,
    output logic [CH-1:0]    conf_flag,
    output logic [CNT_W-1:0] conf_cnt,
    output logic             chg
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CH-1:0] q_next;
    logic          any_conflict;

    assign any_conflict = en & (|(s & r));
    assign qn           = ~q;

    for (genvar i = 0; i < CH; i++) begin : g_cell
        sr_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .s         (s[i]),
            .r         (r[i]),
            .mode      (mode_e'(mode)),
            .clr_conf  (clr_conf),
            .rst_val   (RST_VAL[i]),
            .q         (q[i]),
            .q_next    (q_next[i]),
            .conf_flag (conf_flag[i])
        );
    end

    // Counts cycles with any conflict, not conflicting channels; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conf_cnt <= '0;
            chg      <= 1'b0;
        end else begin
            chg <= (q_next != q);
            if (clr_conf)
                conf_cnt <= any_conflict ? CNT_W'(1) : '0;
            else if (any_conflict && conf_cnt != CNT_MAX)
                conf_cnt <= conf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised, clock-synchronous bank of CH independent set/reset storage cells. It replaces single-bit gated SR latches in the sequential-circuits library. The S=R=1 case is resolved by a run-time selectable mode instead of producing X. Conflicts are reported through sticky per-channel flags and a saturating event counter. The bank sits between control decode and status logic wherever multi-bit set/clear flags are needed.

## Interface
Parameters:
- CH, 8, number of channels (1..32)
- CNT_W, 8, conflict counter width (2..16)
- RST_VAL, {CH{1'b0}}, per-channel q value loaded on reset

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  gate; when 0 the bank holds all q (the "clk low" state of the old latch)
- s  input  CH  per-channel set
- r  input  CH  per-channel reset
- mode  input  2  conflict policy for S=R=1: 0 HOLD, 1 SET_DOM, 2 RST_DOM, 3 TOGGLE
- clr_conf  input  1  clears conflict flags and counter
- q  output  CH  stored values
- qn  output  CH  ~q, always the exact complement of q
- conf_flag  output  CH  sticky per-channel S=R=1 seen
- conf_cnt  output  CNT_W  number of cycles with any conflict, saturating
- chg  output  1  one-cycle pulse: q changed on the last edge

## Operation
- Per channel i, on rising clk with en=1:
  - s=0 r=0 → hold
  - s=0 r=1 → 0
  - s=1 r=0 → 1
  - s=1 r=1 → by mode: HOLD keeps q, SET_DOM gives 1, RST_DOM gives 0, TOGGLE gives ~q
- en=0: q holds.
  - conf_flag and conf_cnt do not update, since conflicts are counted only when gated in.
  - clr_conf still acts.
- Conflict cycle: en=1 and |(s&r)=1.
  - conf_flag[i] sets on each channel with s[i]&r[i].
  - conf_cnt increments by exactly 1 per conflict cycle, regardless of how many channels conflict.
  - conf_cnt saturates at 2^CNT_W−1 and never wraps.
- clr_conf=1 in a conflict cycle: the clear applies first, then the new conflict.
  - conf_flag becomes s&r of that cycle; conf_cnt becomes 1.
  - clr_conf=1 with no conflict: conf_flag=0, conf_cnt=0.
- chg = (q_next != q), registered, so chg is high in the cycle after the edge that changed q.
- mode is sampled every cycle with no internal mode register. A mode change takes effect on the same edge.
- No X is ever produced on any output. Unused mode encodings do not exist, since all 4 are defined.

## Timing
- All outputs are registered; input-to-q latency is 1 clk edge.
- Reset values while rst=1 at an edge: q=RST_VAL, qn=~RST_VAL, conf_flag=0, conf_cnt=0, chg=0.
- rst has priority over en, s, r and clr_conf.
- Reset mid-operation discards the pending update. chg is 0 in the cycle after reset, even if q changed because of the reset.
- TOGGLE with s=r=1 held for N enabled cycles: q alternates every cycle, chg=1 every cycle, and conf_cnt increases by N (saturating).
- Simultaneous set on one channel and conflict on another resolve independently in the same edge.

## Structure
- Package sr_latch_pkg:
  - mode_e enum: MODE_HOLD=2'd0, MODE_SET_DOM=2'd1, MODE_RST_DOM=2'd2, MODE_TOGGLE=2'd3
  - function sr_next(q, s, r, mode) returning the next state
- Sub-module sr_cell, one per channel via generate:
  - holds the q bit and the conf_flag bit
  - inputs: clk, rst, en, s, r, mode, clr_conf, rst_val
- The top level holds the counter, the chg register and the qn assign.

## Test plan
- Reset: CH=8, RST_VAL=8'hA5, rst=1 for 2 cycles → q=A5, qn=5A, conf_flag=0, conf_cnt=0, chg=0.
- Basic: en=1, s=8'h0F, r=8'hF0 from q=A5 → q=0F after 1 edge, chg=1 next cycle. Then s=r=0 → q holds 0F, chg=0.
- Gating: en=0, s=8'hFF → q unchanged and no conf update. With en=0 and s=r=8'h01, conf_cnt stays 0.
- Modes on ch0 with s=r=1, q=0:
  - HOLD → 0
  - SET_DOM → 1
  - RST_DOM → 0
  - TOGGLE for 4 edges → 1,0,1,0
  - conf_flag[0]=1, conf_cnt=7
- Saturation and clear: CNT_W=2, 5 conflict cycles → conf_cnt=3. clr_conf with conflict on ch3 → conf_cnt=1, conf_flag=8'h08. clr_conf alone → all 0.
- Reset mid-TOGGLE: toggling ch0, rst asserted for 1 cycle → q=RST_VAL next edge, chg=0, counter 0. Toggling resumes from RST_VAL after rst drops.
